// File: rtl/mem_req_arbiter.sv
// Two-port round-robin arbiter sharing the DDR2 read/write block between the cache controller (port 0) and the NPU (port 1).
// Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_req_arbiter #(
  parameter int unsigned DATA_WIDTH     = 256,
  parameter int unsigned ADDR_WIDTH     = 31,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_rd_req,
  input  logic                  p0_wr_req,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_done,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  output logic                  p0_err,
  input  logic                  p1_rd_req,
  input  logic                  p1_wr_req,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_done,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  p1_err,
  output logic                  data_wren,
  output logic                  data_rden,
  output logic [ADDR_WIDTH-1:0] data_addr,
  output logic [DATA_WIDTH-1:0] data_wr,
  input  logic [DATA_WIDTH-1:0] data_rd,
  input  logic                  mc_wr_rdy,
  input  logic                  mc_rd_rdy,
  input  logic                  mc_rd_valid,
  output logic                  busy
);

  localparam int unsigned CNT_W = 10;

  typedef enum logic [2:0] {IDLE, LATCH, WR_WAIT, RD_WAIT, DONE} state_e;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  gnt_port_q, gnt_port_d;
  logic                  gnt_wr_q, gnt_wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                  wren_q, wren_d, rden_q, rden_d;
  logic                  done0_q, done0_d, done1_q, done1_d;
  logic                  p0_pend, p1_pend, sel;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err0_q, err0_d, err1_q, err1_d;
  logic                  stall;
`else
  logic [CNT_W-1:0]      unused_timeout;
  assign unused_timeout = CNT_W'(TIMEOUT_CYCLES);
`endif

  assign p0_pend = p0_rd_req | p0_wr_req;
  assign p1_pend = p1_rd_req | p1_wr_req;
  // Port 1 wins when it is alone, or on a tie when port 0 was granted last.
  assign sel     = p1_pend & (~p0_pend | ~last_grant_q);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_port_d   = gnt_port_q;
    gnt_wr_d     = gnt_wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    wren_d       = wren_q;
    rden_d       = rden_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err0_d       = 1'b0;
    err1_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (p0_pend || p1_pend) begin
          gnt_port_d   = sel;
          last_grant_d = sel;
          gnt_wr_d     = sel ? p1_wr_req : p0_wr_req;
          addr_d       = sel ? p1_addr   : p0_addr;
          wdata_d      = sel ? p1_wdata  : p0_wdata;
`ifdef ARB_TIMEOUT_EN
          cnt_d        = '0;
`endif
          state_d      = LATCH;
        end
      end
      LATCH: begin
        if (gnt_wr_q) begin
          wren_d  = 1'b1;
          state_d = WR_WAIT;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (mc_rd_rdy) begin
          rden_d  = 1'b1;
          state_d = RD_WAIT;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      WR_WAIT: begin
        if (mc_wr_rdy) begin
          wren_d  = 1'b0;
          done0_d = ~gnt_port_q;
          done1_d = gnt_port_q;
          state_d = DONE;
        end
      end
      RD_WAIT: begin
        if (mc_rd_valid) begin
          rden_d  = 1'b0;
          done0_d = ~gnt_port_q;
          done1_d = gnt_port_q;
          if (gnt_port_q) rdata1_d = data_rd;
          else            rdata0_d = data_rd;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef ARB_TIMEOUT_EN
    // Timeout exits through DONE so the requester sees done/err while its request is still held.
    stall = ((state_q == LATCH) && !gnt_wr_q && !mc_rd_rdy) ||
            ((state_q == WR_WAIT) && !mc_wr_rdy) ||
            ((state_q == RD_WAIT) && !mc_rd_valid);
    if (stall) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        wren_d  = 1'b0;
        rden_d  = 1'b0;
        done0_d = ~gnt_port_q;
        done1_d = gnt_port_q;
        err0_d  = ~gnt_port_q;
        err1_d  = gnt_port_q;
        state_d = DONE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_port_q   <= 1'b0;
      gnt_wr_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      wren_q       <= 1'b0;
      rden_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q        <= '0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_port_q   <= gnt_port_d;
      gnt_wr_q     <= gnt_wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      wren_q       <= wren_d;
      rden_q       <= rden_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
`endif
    end
  end

  assign data_wren = wren_q;
  assign data_rden = rden_q;
  assign data_addr = addr_q;
  assign data_wr   = wdata_q;
  assign p0_done   = done0_q;
  assign p1_done   = done1_q;
  assign p0_rdata  = rdata0_q;
  assign p1_rdata  = rdata1_q;
  assign busy      = (state_q != IDLE);
`ifdef ARB_TIMEOUT_EN
  assign p0_err    = err0_q;
  assign p1_err    = err1_q;
`else
  assign p0_err    = 1'b0;
  assign p1_err    = 1'b0;
`endif

endmodule
